// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the 32x32 register file: arbitrates WB writes against
// queued load returns, tracks pending loads and raises ID stalls on RAW/WAW hazards.
module regfile_wr_sched #(
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        rst,
    input  logic        dclk,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [4:0]  ld_rd_i,
    input  logic [31:0] ld_data_i,
    input  logic        iss_load_i,
    input  logic [4:0]  iss_rd_i,
    input  logic        id_re1_i,
    input  logic [4:0]  id_raddr1_i,
    input  logic        id_re2_i,
    input  logic [4:0]  id_raddr2_i,
    input  logic        id_rd_we_i,
    input  logic [4:0]  id_rd_i,
    output logic        stall_ID_o,
    output logic        hold_WB_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] pending_o
);

    localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    logic [4:0]    q_rd   [LQ_DEPTH];
    logic [31:0]   q_data [LQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   pending, pending_next;
    logic          ld_ready, hold_wb;
    logic          empty, src_a, head_grant, push, store;

    assign empty      = (count == '0);
    assign push       = ld_valid_i && ld_ready;
    // Returns to x0 complete the handshake but never occupy a slot.
    assign store      = push && (ld_rd_i != 5'd0);
    assign src_a      = !rst && wb_we_i && (wb_waddr_i != 5'd0) && !hold_wb;
    assign head_grant = !rst && !src_a && !empty;

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (src_a) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = wb_waddr_i;
            rf_wdata_o = wb_wdata_i;
        end else if (head_grant) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = q_rd[rd_ptr];
            rf_wdata_o = q_data[rd_ptr];
        end
    end

    always_comb begin
        count_next = count;
        if (store)      count_next = count_next + CW'(1);
        if (head_grant) count_next = count_next - CW'(1);
    end

    // Clear is applied before set so a same-cycle re-issue keeps the bit.
    always_comb begin
        pending_next = pending;
        if (head_grant) pending_next[q_rd[rd_ptr]] = 1'b0;
        if (iss_load_i && (iss_rd_i != 5'd0)) pending_next[iss_rd_i] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // NOTE: the queue storage is deliberately not reset; clearing the pointers and count empties it.
    always_ff @(posedge dclk) begin
        if (store) begin
            q_rd[wr_ptr]   <= ld_rd_i;
            q_data[wr_ptr] <= ld_data_i;
        end
    end

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ld_ready   <= 1'b0;
            pending    <= '0;
            starve_cnt <= '0;
            hold_wb    <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignments so every update sees pre-edge values.
            if (store)      wr_ptr <= wr_ptr + PW'(1);
            if (head_grant) rd_ptr <= rd_ptr + PW'(1);
            count    <= count_next;
            ld_ready <= (count_next != CW'(LQ_DEPTH));
            pending  <= pending_next;
            if (!empty && !head_grant) begin
                if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
                    starve_cnt <= '0;
                    hold_wb    <= 1'b1;
                end else begin
                    starve_cnt <= starve_cnt + SW'(1);
                    hold_wb    <= 1'b0;
                end
            end else begin
                starve_cnt <= '0;
                hold_wb    <= 1'b0;
            end
        end
    end

    assign ld_ready_o = ld_ready;
    assign hold_WB_o  = hold_wb;
    assign pending_o  = pending;
    assign stall_ID_o = (id_re1_i   && pending[id_raddr1_i]) ||
                        (id_re2_i   && pending[id_raddr2_i]) ||
                        (id_rd_we_i && pending[id_rd_i]);

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Scoreboard bench for regfile_wr_sched: a queue-based reference model predicts each
// cycle's writes and status, and a negedge monitor compares them against the DUT.
module tb_regfile_wr_sched;

    localparam int LQ_DEPTH     = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed { logic [4:0] rd; logic [31:0] data; } entry_t;
    typedef struct packed { logic stall; logic hold; logic ready; logic we; logic [31:0] pend; } stat_t;

    logic        rst = 1'b0;
    logic        dclk = 1'b0;
    logic        wb_we_i, ld_valid_i, iss_load_i, id_re1_i, id_re2_i, id_rd_we_i;
    logic [4:0]  wb_waddr_i, ld_rd_i, iss_rd_i, id_raddr1_i, id_raddr2_i, id_rd_i;
    logic [31:0] wb_wdata_i, ld_data_i;
    logic        ld_ready_o, stall_ID_o, hold_WB_o, rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o, pending_o;

    regfile_wr_sched #(.LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .rst(rst), .dclk(dclk),
        .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i),
        .iss_load_i(iss_load_i), .iss_rd_i(iss_rd_i),
        .id_re1_i(id_re1_i), .id_raddr1_i(id_raddr1_i),
        .id_re2_i(id_re2_i), .id_raddr2_i(id_raddr2_i),
        .id_rd_we_i(id_rd_we_i), .id_rd_i(id_rd_i),
        .stall_ID_o(stall_ID_o), .hold_WB_o(hold_WB_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .pending_o(pending_o)
    );

    always #5 dclk = ~dclk;

    int checks = 0;
    int errors = 0;

    // Reference model state and scoreboard queues
    entry_t      m_q[$];
    logic [31:0] m_pend;
    int          m_cnt;
    logic        m_hold;
    entry_t      exp_wr[$];
    stat_t       exp_st[$];
    logic [4:0]  outstanding[$];
    logic        l_we;
    logic [4:0]  l_wa;
    logic [31:0] l_wd;
    logic        last_acc;

    // Next-cycle stimulus, consumed and cleared by step()
    logic        n_wb_we, n_lv, n_il, n_r1, n_r2, n_rw;
    logic [4:0]  n_wa, n_lr, n_ir, n_a1, n_a2, n_rd;
    logic [31:0] n_wd, n_ld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_next();
        n_wb_we = 0; n_wa = 0; n_wd = 0; n_lv = 0; n_lr = 0; n_ld = 0;
        n_il = 0; n_ir = 0; n_r1 = 0; n_a1 = 0; n_r2 = 0; n_a2 = 0; n_rw = 0; n_rd = 0;
    endtask

    task automatic step();
        stat_t  st;
        entry_t e;
        logic   ready, a, grant, nonempty;
        if (m_hold) begin
            n_wb_we = l_we; n_wa = l_wa; n_wd = l_wd;
        end
        l_we = n_wb_we; l_wa = n_wa; l_wd = n_wd;
        wb_we_i = n_wb_we; wb_waddr_i = n_wa; wb_wdata_i = n_wd;
        ld_valid_i = n_lv; ld_rd_i = n_lr; ld_data_i = n_ld;
        iss_load_i = n_il; iss_rd_i = n_ir;
        id_re1_i = n_r1; id_raddr1_i = n_a1; id_re2_i = n_r2; id_raddr2_i = n_a2;
        id_rd_we_i = n_rw; id_rd_i = n_rd;

        ready    = (m_q.size() < LQ_DEPTH);
        nonempty = (m_q.size() > 0);
        a        = n_wb_we && (n_wa != 0) && !m_hold;
        grant    = !a && nonempty;
        if (a) begin
            e.rd = n_wa; e.data = n_wd;
            exp_wr.push_back(e);
        end else if (grant) begin
            exp_wr.push_back(m_q[0]);
        end
        st.we    = a || grant;
        st.stall = (n_r1 && m_pend[n_a1]) || (n_r2 && m_pend[n_a2]) || (n_rw && m_pend[n_rd]);
        st.hold  = m_hold;
        st.ready = ready;
        st.pend  = m_pend;
        exp_st.push_back(st);

        last_acc = n_lv && ready;
        if (grant) begin
            m_pend[m_q[0].rd] = 1'b0;
            m_q.delete(0);
        end
        if (last_acc && n_lr != 0) begin
            e.rd = n_lr; e.data = n_ld;
            m_q.push_back(e);
        end
        if (n_il && n_ir != 0) m_pend[n_ir] = 1'b1;
        if (nonempty && !grant) begin
            m_cnt++;
            m_hold = (m_cnt == STARVE_LIMIT);
            if (m_hold) m_cnt = 0;
        end else begin
            m_cnt = 0;
            m_hold = 1'b0;
        end
        clear_next();
        @(posedge dclk);
        #1;
    endtask

    task automatic do_reset();
        clear_next();
        wb_we_i = 0; wb_waddr_i = 0; wb_wdata_i = 0; ld_valid_i = 0; ld_rd_i = 0; ld_data_i = 0;
        iss_load_i = 0; iss_rd_i = 0; id_re1_i = 0; id_raddr1_i = 0; id_re2_i = 0; id_raddr2_i = 0;
        id_rd_we_i = 0; id_rd_i = 0;
        rst = 1'b1;
        #1;
        check("rst_rf_we", rf_we_o, 0);
        check("rst_rf_waddr", rf_waddr_o, 0);
        check("rst_rf_wdata", rf_wdata_o, 0);
        check("rst_pending", pending_o, 0);
        check("rst_stall", stall_ID_o, 0);
        check("rst_hold", hold_WB_o, 0);
        check("rst_ld_ready", ld_ready_o, 0);
        m_q.delete(); outstanding.delete();
        m_pend = 0; m_cnt = 0; m_hold = 0; l_we = 0; l_wa = 0; l_wd = 0; last_acc = 0;
        repeat (2) @(posedge dclk);
        @(negedge dclk);
        #1;
        rst = 1'b0;
        @(posedge dclk);
        #1;
    endtask

    stat_t  mon_st;
    entry_t mon_w;
    always @(negedge dclk) begin
        if (!rst) begin
            if (exp_st.size() > 0) begin
                mon_st = exp_st.pop_front();
                check("stall_ID", stall_ID_o, mon_st.stall);
                check("hold_WB", hold_WB_o, mon_st.hold);
                check("ld_ready", ld_ready_o, mon_st.ready);
                check("rf_we", rf_we_o, mon_st.we);
                check("pending", pending_o, mon_st.pend);
            end
            if (rf_we_o) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got x%0d=%0h expected no write at %0t",
                             rf_waddr_o, rf_wdata_o, $time);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("rf_waddr", rf_waddr_o, mon_w.rd);
                    check("rf_wdata", rf_wdata_o, mon_w.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int tries;
        #2;
        do_reset();
        repeat (2) step();

        // Load to x5: stall through the write cycle, clear afterwards
        n_il = 1; n_ir = 5; step();
        n_r1 = 1; n_a1 = 5; step();
        n_r1 = 1; n_a1 = 5; n_lv = 1; n_lr = 5; n_ld = 32'hDEADBEEF; step();
        n_r1 = 1; n_a1 = 5; step();
        n_r1 = 1; n_a1 = 5; step();

        // WB beats a queued load; load drains when WB goes quiet
        n_il = 1; n_ir = 7; step();
        n_lv = 1; n_lr = 7; n_ld = 32'h22; n_wb_we = 1; n_wa = 3; n_wd = 32'h11; step();
        n_wb_we = 1; n_wa = 3; n_wd = 32'h11; n_rw = 1; n_rd = 7; step();
        step();
        step();

        // Starvation: WB busy every cycle with one queued load
        n_il = 1; n_ir = 9; step();
        n_lv = 1; n_lr = 9; n_ld = 32'h99; n_wb_we = 1; n_wa = 10; n_wd = 32'h100; step();
        for (int i = 1; i < 9; i++) begin
            n_wb_we = 1; n_wa = 10; n_wd = 32'h100 + i; step();
        end
        step();

        // Same-register set and clear in one cycle: set wins
        n_il = 1; n_ir = 12; step();
        n_lv = 1; n_lr = 12; n_ld = 32'h12; n_wb_we = 1; n_wa = 4; n_wd = 32'h4; step();
        n_il = 1; n_ir = 12; step();
        n_r2 = 1; n_a2 = 12; step();

        // Fill the queue while WB is busy; third return is held off until a pop
        n_il = 1; n_ir = 13; step();
        n_il = 1; n_ir = 14; step();
        n_il = 1; n_ir = 15; step();
        n_lv = 1; n_lr = 13; n_ld = 32'h1313; n_wb_we = 1; n_wa = 2; n_wd = 32'h200; step();
        n_lv = 1; n_lr = 14; n_ld = 32'h1414; n_wb_we = 1; n_wa = 2; n_wd = 32'h201; step();
        tries = 0;
        do begin
            n_lv = 1; n_lr = 15; n_ld = 32'h1515; n_wb_we = 1; n_wa = 2; n_wd = 32'h202 + tries;
            step();
            tries++;
        end while (!last_acc && tries < 20);
        repeat (4) step();

        // x0 traffic: neither a load return nor a WB write to x0 reaches the port
        n_lv = 1; n_lr = 0; n_ld = 32'hBAD0; n_wb_we = 1; n_wa = 0; n_wd = 32'hBAD1; step();
        repeat (2) step();

        // Reset with two entries queued
        n_il = 1; n_ir = 16; step();
        n_il = 1; n_ir = 17; step();
        n_lv = 1; n_lr = 16; n_ld = 32'h1616; n_wb_we = 1; n_wa = 1; n_wd = 32'h1; step();
        n_lv = 1; n_lr = 17; n_ld = 32'h1717; n_wb_we = 1; n_wa = 1; n_wd = 32'h2; step();
        do_reset();
        repeat (3) step();

        // Randomized traffic honouring one outstanding load per register
        for (int c = 0; c < 3000; c++) begin
            int         idx;
            logic [4:0] ir;
            logic       iss;
            idx = -1;
            iss = 0;
            if (outstanding.size() > 0 && $urandom_range(0, 2) == 0) begin
                idx = int'($urandom_range(0, outstanding.size() - 1));
                n_lv = 1; n_lr = outstanding[idx]; n_ld = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                n_lv = 1; n_lr = 0; n_ld = $urandom;
            end
            n_wb_we = ($urandom_range(0, 3) != 0);
            n_wa = 5'($urandom_range(0, 31));
            n_wd = $urandom;
            ir = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0 && ir != 0 && !m_pend[ir]) begin
                iss = 1; n_il = 1; n_ir = ir;
            end
            n_r1 = 1'($urandom_range(0, 1)); n_a1 = 5'($urandom_range(0, 31));
            n_r2 = 1'($urandom_range(0, 1)); n_a2 = 5'($urandom_range(0, 31));
            n_rw = 1'($urandom_range(0, 1)); n_rd = 5'($urandom_range(0, 31));
            step();
            if (idx >= 0 && last_acc) outstanding.delete(idx);
            if (iss) outstanding.push_back(ir);
        end
        repeat (20) step();
        @(negedge dclk);
        #1;
        check("wr_scoreboard_drained", exp_wr.size(), 0);
        check("status_scoreboard_drained", exp_st.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
